// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit MIPS pipeline MEM stage.
package mips_pkg;
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller and a multi-cycle memory.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = mips_pkg::DATA_W
);
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [DATA_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic              dmem_ack_i;
    logic [DATA_W-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the control bits and holds the data fields.
module mem_wb_reg #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic [REG_AW-1:0] rdaddr,
    input  logic [DATA_W-1:0] wbdata,
    output logic              RegWrite_WB,
    output logic              MemtoReg_WB,
    output logic [REG_AW-1:0] RDaddr_WB,
    output logic [DATA_W-1:0] WBdata_WB
);
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_WB <= 1'b0;
            MemtoReg_WB <= 1'b0;
            RDaddr_WB   <= '0;
            WBdata_WB   <= '0;
        end else if (bubble) begin
            RegWrite_WB <= 1'b0;
            MemtoReg_WB <= 1'b0;
        end else begin
            RegWrite_WB <= regwrite;
            MemtoReg_WB <= memtoreg;
            RDaddr_WB   <= rdaddr;
            WBdata_WB   <= wbdata;
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues loads/stores over req/ack, stalls while busy, feeds MEM/WB.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DATA_W         = mips_pkg::DATA_W,
    parameter int REG_AW         = mips_pkg::REG_AW,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              RegWrite_MEM,
    input  logic              MemtoReg_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic [REG_AW-1:0] RDaddr_MEM,
    input  logic [DATA_W-1:0] FUResult_MEM,
    input  logic [DATA_W-1:0] rtdata_MEM,
    mem_stage_ctrl_if.master  dmem,
    output logic              stall_o,
    output logic              RegWrite_WB,
    output logic              MemtoReg_WB,
    output logic [REG_AW-1:0] RDaddr_WB,
    output logic [DATA_W-1:0] WBdata_WB,
    output logic              err_o
);
    import mips_pkg::*;

    mem_state_t        state;
    logic              req_q, we_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              mem_op, tmo, done;
    logic [DATA_W-1:0] rdata_eff, wbdata_d;

    assign mem_op  = MemRead_MEM | MemWrite_MEM;
    // A timeout completes the op exactly like an ack, so stall drops in that cycle.
    assign done    = (state == BUSY) & (dmem.dmem_ack_i | tmo);
    assign stall_o = mem_op & ~done;

`ifdef MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    assign tmo   = (state == BUSY) & ~dmem.dmem_ack_i & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == BUSY) ? tmo_cnt + 16'd1 : '0;
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (mem_op) begin
                    state   <= BUSY;
                    req_q   <= 1'b1;
                    we_q    <= MemWrite_MEM;
                    addr_q  <= FUResult_MEM;
                    wdata_q <= rtdata_MEM;
                end
                BUSY: if (done) begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;

    assign rdata_eff = tmo ? '0 : dmem.dmem_rdata_i;
    assign wbdata_d  = MemtoReg_MEM ? rdata_eff : FUResult_MEM;

    mem_wb_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mem_wb (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .bubble      (stall_o),
        .regwrite    (RegWrite_MEM),
        .memtoreg    (MemtoReg_MEM),
        .rdaddr      (RDaddr_MEM),
        .wbdata      (wbdata_d),
        .RegWrite_WB (RegWrite_WB),
        .MemtoReg_WB (MemtoReg_WB),
        .RDaddr_WB   (RDaddr_WB),
        .WBdata_WB   (WBdata_WB)
    );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, reset/timeout sequences, random program.
module tb_mem_stage_ctrl;
    localparam int TMO = 15;

    logic        clk, rst_n;
    logic        RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM;
    logic [2:0]  RDaddr_MEM;
    logic [15:0] FUResult_MEM, rtdata_MEM;
    logic        stall_o, RegWrite_WB, MemtoReg_WB, err_o;
    logic [2:0]  RDaddr_WB;
    logic [15:0] WBdata_WB;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;
    int exp_req = 0;
    logic req_prev = 1'b0;

    mem_stage_ctrl_if #(.DATA_W(16)) mif ();

    mem_stage_ctrl #(.DATA_W(16), .REG_AW(3), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .RDaddr_MEM(RDaddr_MEM), .FUResult_MEM(FUResult_MEM), .rtdata_MEM(rtdata_MEM),
        .dmem(mif), .stall_o(stall_o),
        .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
        .RDaddr_WB(RDaddr_WB), .WBdata_WB(WBdata_WB), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of request issues (rising edges of req).
    always @(negedge clk) begin
        if (mif.dmem_req_o && !req_prev) n_req++;
        req_prev = mif.dmem_req_o;
    end

    typedef struct {
        logic        rw, m2r, mr, mw;
        logic [2:0]  rd;
        logic [15:0] fu, rt, rdata;
        int          d;
        logic        exp_we, exp_rw;
        logic [15:0] exp_wb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Present one instruction; the memory acks d cycles after req first becomes visible
    // (never, if noack). Expected stall length is 1+d for memory ops, 0 otherwise.
    task automatic run_instr(input vec_t v, input logic noack);
        logic mem, ack_now, exp_st;
        int   lim;
        mem = v.mr | v.mw;
        lim = mem ? v.d + 1 : 0;
        RegWrite_MEM = v.rw; MemtoReg_MEM = v.m2r; MemRead_MEM = v.mr; MemWrite_MEM = v.mw;
        RDaddr_MEM = v.rd; FUResult_MEM = v.fu; rtdata_MEM = v.rt;
        if (mem) exp_req++;
        for (int k = 0; k <= lim; k++) begin
            ack_now = mem && !noack && (k == v.d + 1);
            mif.dmem_ack_i   = ack_now;
            mif.dmem_rdata_i = ack_now ? v.rdata : 16'($urandom);
            exp_st = mem && (k < v.d + 1);
            @(negedge clk);
            chk("stall", stall_o, exp_st);
            if (k == 0) chk("req_idle", mif.dmem_req_o, 1'b0);
            if (mem && k > 0) begin
                chk("req_held", mif.dmem_req_o, 1'b1);
                chk("we", mif.dmem_we_o, v.exp_we);
                chk("addr", mif.dmem_addr_o, v.fu);
                chk("wdata", mif.dmem_wdata_o, v.rt);
            end
            @(posedge clk); #1;
            if (exp_st) begin
                chk("bubble_rw", RegWrite_WB, 1'b0);
                chk("bubble_m2r", MemtoReg_WB, 1'b0);
            end else begin
                chk("wb_rw", RegWrite_WB, v.exp_rw);
                chk("wb_m2r", MemtoReg_WB, v.m2r);
                chk("wb_rd", RDaddr_WB, v.rd);
                chk("wb_data", WBdata_WB, v.exp_wb);
                if (mem) chk("req_drop", mif.dmem_req_o, 1'b0);
            end
        end
        mif.dmem_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        RegWrite_MEM = 0; MemtoReg_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
        RDaddr_MEM = '0; FUResult_MEM = '0; rtdata_MEM = '0;
        mif.dmem_ack_i = 1'b0; mif.dmem_rdata_i = '0;

        //             rw    m2r   mr    mw    rd    fu        rt        rdata     d  we    rw    wb
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h0040, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0010, 16'hA5A5, 16'h0000, 0, 1'b1, 1'b0, 16'h0010};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 16'h0080, 16'h0000, 16'h1111, 0, 1'b0, 1'b1, 16'h1111};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0090, 16'h5A5A, 16'h0000, 0, 1'b1, 1'b0, 16'h0090};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 16'h0022, 16'hCAFE, 16'h7777, 1, 1'b1, 1'b1, 16'h7777};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 16'hFFFF};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mif.dmem_req_o, 1'b0);
        chk("rst_rw", RegWrite_WB, 1'b0);
        chk("rst_wbdata", WBdata_WB, 16'h0000);
        chk("rst_err", err_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_instr(vecs[i], 1'b0);

        // Reset in the middle of an outstanding load, then a stray ack.
        RegWrite_MEM = 1; MemtoReg_MEM = 1; MemRead_MEM = 1; MemWrite_MEM = 0;
        RDaddr_MEM = 3'd2; FUResult_MEM = 16'h0300;
        exp_req++;
        @(posedge clk); #1;
        chk("mid_req", mif.dmem_req_o, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_req", mif.dmem_req_o, 1'b0);
        chk("async_wbdata", WBdata_WB, 16'h0000);
        chk("async_rd", RDaddr_WB, 3'd0);
        chk("async_rw", RegWrite_WB, 1'b0);
        RegWrite_MEM = 0; MemtoReg_MEM = 0; MemRead_MEM = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.dmem_ack_i = 1'b1;
        @(negedge clk);
        chk("late_ack_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        mif.dmem_ack_i = 1'b0;
        chk("late_ack_req", mif.dmem_req_o, 1'b0);
        run_instr(vecs[1], 1'b0);

`ifdef MEM_TIMEOUT_EN
        v = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0500, 16'h0000, 16'hDEAD, TMO - 1, 1'b0, 1'b1, 16'h0000};
        run_instr(v, 1'b1);
        chk("tmo_err", err_o, 1'b1);
        run_instr(vecs[0], 1'b0);
        chk("tmo_err_sticky", err_o, 1'b1);
`else
        chk("err_tied", err_o, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic mem;
            mem = 1'($urandom_range(0, 1));
            v.rw = 1'($urandom); v.rd = 3'($urandom);
            v.fu = 16'($urandom); v.rt = 16'($urandom); v.rdata = 16'($urandom);
            v.d = $urandom_range(0, 4);
            if (mem) begin
                case ($urandom_range(0, 2))
                    0: begin v.mr = 1; v.mw = 0; end
                    1: begin v.mr = 0; v.mw = 1; end
                    default: begin v.mr = 1; v.mw = 1; end
                endcase
                v.m2r = 1'($urandom);
            end else begin
                v.mr = 0; v.mw = 0; v.m2r = 0;
            end
            v.exp_we = v.mw;
            v.exp_rw = v.rw;
            v.exp_wb = v.m2r ? v.rdata : v.fu;
            run_instr(v, 1'b0);
        end

        @(negedge clk);
        chk("req_count", n_req, exp_req);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
